// File: rtl/dmem_arbiter_pkg.sv
// Shared types and funct3 encodings for the data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_HOST = 2'd2
    } owner_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Context carried alongside a read from grant to data return.
    typedef struct packed {
        owner_e     owner;
        logic       zero_data;
        logic [1:0] off;
        logic [2:0] funct3;
    } rd_ctx_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Core, host and BRAM signal bundle; slave is the arbiter's view.
interface dmem_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 12
);
    logic                  core_req;
    logic                  core_we;
    logic [ADDR_WIDTH+1:0] core_addr;
    logic [2:0]            core_funct3;
    logic [31:0]           core_wdata;
    logic                  core_gnt;
    logic                  core_misalign;
    logic                  core_rvalid;
    logic [31:0]           core_rdata;
    logic [1:0]            core_rd_offset;
    logic [2:0]            core_rd_funct3;

    logic                  host_req;
    logic                  host_we;
    logic [ADDR_WIDTH-1:0] host_addr;
    logic [3:0]            host_be;
    logic [31:0]           host_wdata;
    logic                  host_gnt;
    logic                  host_rvalid;
    logic [31:0]           host_rdata;

    logic                  mem_en;
    logic [3:0]            mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic [31:0]           mem_rdata;

    modport slave (
        input  core_req, core_we, core_addr, core_funct3, core_wdata,
        output core_gnt, core_misalign, core_rvalid, core_rdata,
               core_rd_offset, core_rd_funct3,
        input  host_req, host_we, host_addr, host_be, host_wdata,
        output host_gnt, host_rvalid, host_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output core_req, core_we, core_addr, core_funct3, core_wdata,
        input  core_gnt, core_misalign, core_rvalid, core_rdata,
               core_rd_offset, core_rd_funct3,
        output host_req, host_we, host_addr, host_be, host_wdata,
        input  host_gnt, host_rvalid, host_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/dmem_arbiter_store_lane_gen.sv
// Byte enables, lane-replicated store data and misalignment for a core access.
module store_lane_gen
    import dmem_arb_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    output logic [3:0]  be_c,
    output logic [31:0] lane_wdata_c,
    output logic        misalign_c
);

    // Size decode; anything not byte or half is handled as a word.
    always_comb begin
        be_c         = 4'b1111;
        lane_wdata_c = wdata;
        misalign_c   = (off != 2'b00);
        case (funct3)
            F3_B, F3_BU: begin
                be_c         = 4'b0001 << off;
                lane_wdata_c = {4{wdata[7:0]}};
                misalign_c   = 1'b0;
            end
            F3_H, F3_HU: begin
                be_c         = 4'b0011 << {off[1], 1'b0};
                lane_wdata_c = {2{wdata[15:0]}};
                misalign_c   = off[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: core priority, 1-cycle read return.
// Optional build macro HOST_FAIRNESS_EN lets a starved host win a conflict.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 12,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic           i_clk,
    input  logic           i_rst,
    dmem_arbiter_if.slave  bus
);

    if (STARVE_LIMIT == 0) begin : g_bad_limit
        $error("STARVE_LIMIT must be nonzero");
    end

    logic [3:0]  be_c;
    logic [31:0] lane_wdata_c;
    logic        misalign_c;
    logic        host_prio;
    logic        core_gnt_c;
    logic        host_gnt_c;
    logic        core_rv_c;
    logic        host_rv_c;
    rd_ctx_t     ctx_d;
    rd_ctx_t     ctx_q;

    store_lane_gen u_lane (
        .funct3       (bus.core_funct3),
        .off          (bus.core_addr[1:0]),
        .wdata        (bus.core_wdata),
        .be_c         (be_c),
        .lane_wdata_c (lane_wdata_c),
        .misalign_c   (misalign_c)
    );

`ifdef HOST_FAIRNESS_EN
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
    logic [CNT_W-1:0] starve_cnt;

    assign host_prio = (starve_cnt == CNT_W'(STARVE_LIMIT));

    // Count conflicts the host lost; any host grant or idle host clears it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            starve_cnt <= '0;
        end else if (!bus.host_req || host_gnt_c) begin
            starve_cnt <= '0;
        end else if (core_gnt_c) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end
`else
    assign host_prio = 1'b0;
`endif

    // Grant selection: core wins unless the host has earned priority.
    always_comb begin
        core_gnt_c = ~i_rst & bus.core_req & ~(bus.host_req & host_prio);
        host_gnt_c = ~i_rst & bus.host_req & ~core_gnt_c;
    end

    // Memory drive and read-context capture for the granted access.
    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 4'b0000;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        ctx_d         = '0;
        ctx_d.owner   = OWN_NONE;
        if (core_gnt_c) begin
            bus.mem_en   = ~misalign_c;
            bus.mem_addr = bus.core_addr[ADDR_WIDTH+1:2];
            if (bus.core_we && !misalign_c) begin
                bus.mem_we    = be_c;
                bus.mem_wdata = lane_wdata_c;
            end
            if (!bus.core_we) begin
                ctx_d.owner     = OWN_CORE;
                ctx_d.zero_data = misalign_c;
                ctx_d.off       = bus.core_addr[1:0];
                ctx_d.funct3    = bus.core_funct3;
            end
        end else if (host_gnt_c) begin
            bus.mem_en   = 1'b1;
            bus.mem_addr = bus.host_addr;
            if (bus.host_we) begin
                bus.mem_we    = bus.host_be;
                bus.mem_wdata = bus.host_wdata;
            end else begin
                ctx_d.owner = OWN_HOST;
            end
        end
    end

    // Read-return context register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ctx_q <= '0;
        end else begin
            ctx_q <= ctx_d;
        end
    end

    // Route returned data to the owner only; everything reads zero in reset.
    always_comb begin
        core_rv_c          = ~i_rst & (ctx_q.owner == OWN_CORE);
        host_rv_c          = ~i_rst & (ctx_q.owner == OWN_HOST);
        bus.core_gnt       = core_gnt_c;
        bus.host_gnt       = host_gnt_c;
        bus.core_misalign  = core_gnt_c & misalign_c;
        bus.core_rvalid    = core_rv_c;
        bus.core_rdata     = (core_rv_c && !ctx_q.zero_data) ? bus.mem_rdata : 32'd0;
        bus.core_rd_offset = core_rv_c ? ctx_q.off : 2'd0;
        bus.core_rd_funct3 = core_rv_c ? ctx_q.funct3 : 3'd0;
        bus.host_rvalid    = host_rv_c;
        bus.host_rdata     = host_rv_c ? bus.mem_rdata : 32'd0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a read-first BRAM model.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int unsigned AW = 12;
`ifdef HOST_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    logic [31:0] mem [0:(1<<AW)-1];

    dmem_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

    dmem_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(4)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-first synchronous BRAM.
    always @(posedge clk) begin
        if (bus.mem_en) begin
            bus.mem_rdata <= mem[bus.mem_addr];
            for (int b = 0; b < 4; b++) begin
                if (bus.mem_we[b]) mem[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic core_drive(input logic we, input logic [AW+1:0] addr,
                              input logic [2:0] f3, input logic [31:0] wd);
        bus.core_req    = 1'b1;
        bus.core_we     = we;
        bus.core_addr   = addr;
        bus.core_funct3 = f3;
        bus.core_wdata  = wd;
    endtask

    task automatic host_drive(input logic we, input logic [AW-1:0] addr,
                              input logic [3:0] be, input logic [31:0] wd);
        bus.host_req   = 1'b1;
        bus.host_we    = we;
        bus.host_addr  = addr;
        bus.host_be    = be;
        bus.host_wdata = wd;
    endtask

    task automatic idle();
        bus.core_req = 1'b0;
        bus.host_req = 1'b0;
    endtask

    initial begin
        logic exp_h;
        vectors     = 0;
        miscompares = 0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'd0;
        mem[12'h004] = 32'hDEADBEEF;
        mem[12'h020] = 32'hCAFEF00D;
        bus.mem_rdata = 32'd0;
        core_drive(1'b0, '0, F3_W, 32'd0);
        host_drive(1'b0, '0, 4'b0000, 32'd0);
        idle();
        rst = 1'b1;
        tick();
        tick();

        // Reset state
        chk("rst_core_gnt", 32'(bus.core_gnt), 32'd0);
        chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
        chk("rst_core_rvalid", 32'(bus.core_rvalid), 32'd0);
        chk("rst_host_rvalid", 32'(bus.host_rvalid), 32'd0);
        rst = 1'b0;
        tick();

        // Core LW at 0x010
        core_drive(1'b0, 14'h010, F3_W, 32'd0);
        #2;
        chk("lw_gnt", 32'(bus.core_gnt), 32'd1);
        chk("lw_mem_en", 32'(bus.mem_en), 32'd1);
        chk("lw_mem_addr", 32'(bus.mem_addr), 32'h004);
        chk("lw_mem_we", 32'(bus.mem_we), 32'd0);
        tick();
        idle();
        chk("lw_rvalid", 32'(bus.core_rvalid), 32'd1);
        chk("lw_rdata", bus.core_rdata, 32'hDEADBEEF);
        chk("lw_offset", 32'(bus.core_rd_offset), 32'd0);
        chk("lw_funct3", 32'(bus.core_rd_funct3), 32'd2);
        chk("lw_host_rvalid", 32'(bus.host_rvalid), 32'd0);
        chk("lw_host_rdata", bus.host_rdata, 32'd0);

        // Core SB at 0x013
        core_drive(1'b1, 14'h013, F3_B, 32'h000000A5);
        #2;
        chk("sb_gnt", 32'(bus.core_gnt), 32'd1);
        chk("sb_mem_we", 32'(bus.mem_we), 32'h8);
        chk("sb_mem_wdata", bus.mem_wdata, 32'hA5A5A5A5);
        chk("sb_mem_addr", 32'(bus.mem_addr), 32'h004);
        chk("sb_misalign", 32'(bus.core_misalign), 32'd0);
        tick();
        idle();
        chk("sb_no_rvalid", 32'(bus.core_rvalid), 32'd0);

        // Misaligned SH at 0x011: granted, no access
        core_drive(1'b1, 14'h011, F3_H, 32'h00001234);
        #2;
        chk("sh_mis_gnt", 32'(bus.core_gnt), 32'd1);
        chk("sh_mis_flag", 32'(bus.core_misalign), 32'd1);
        chk("sh_mis_mem_en", 32'(bus.mem_en), 32'd0);
        chk("sh_mis_mem_we", 32'(bus.mem_we), 32'd0);
        tick();
        idle();
        chk("sh_mis_no_rvalid", 32'(bus.core_rvalid), 32'd0);

        // Misaligned LH at 0x011: rvalid with zero data
        core_drive(1'b0, 14'h011, F3_H, 32'd0);
        #2;
        chk("lh_mis_flag", 32'(bus.core_misalign), 32'd1);
        chk("lh_mis_mem_en", 32'(bus.mem_en), 32'd0);
        tick();
        idle();
        chk("lh_mis_rvalid", 32'(bus.core_rvalid), 32'd1);
        chk("lh_mis_rdata", bus.core_rdata, 32'd0);
        chk("lh_mis_offset", 32'(bus.core_rd_offset), 32'd1);
        chk("lh_mis_funct3", 32'(bus.core_rd_funct3), 32'd1);

        // LBU readback of the word touched by SB / skipped SH
        core_drive(1'b0, 14'h013, F3_BU, 32'd0);
        #2;
        chk("lbu_misalign", 32'(bus.core_misalign), 32'd0);
        tick();
        idle();
        chk("lbu_rdata", bus.core_rdata, 32'hA5ADBEEF);
        chk("lbu_offset", 32'(bus.core_rd_offset), 32'd3);
        chk("lbu_funct3", 32'(bus.core_rd_funct3), 32'd4);

        // Aligned SH at 0x016 (upper half)
        core_drive(1'b1, 14'h016, F3_H, 32'h0000BEEF);
        #2;
        chk("sh_mem_we", 32'(bus.mem_we), 32'hC);
        chk("sh_mem_wdata", bus.mem_wdata, 32'hBEEFBEEF);
        chk("sh_mem_addr", 32'(bus.mem_addr), 32'h005);
        tick();
        idle();

        // Misaligned SW at 0x012
        core_drive(1'b1, 14'h012, F3_W, 32'hFFFFFFFF);
        #2;
        chk("sw_mis_flag", 32'(bus.core_misalign), 32'd1);
        chk("sw_mis_mem_we", 32'(bus.mem_we), 32'd0);
        tick();
        idle();

        // Host read word 0x020, then core SW to same word (read-first)
        host_drive(1'b0, 12'h020, 4'b0000, 32'd0);
        #2;
        chk("hrd_gnt", 32'(bus.host_gnt), 32'd1);
        chk("hrd_core_gnt", 32'(bus.core_gnt), 32'd0);
        chk("hrd_mem_addr", 32'(bus.mem_addr), 32'h020);
        tick();
        idle();
        core_drive(1'b1, 14'h080, F3_W, 32'h12345678);
        #2;
        chk("hrd_rvalid", 32'(bus.host_rvalid), 32'd1);
        chk("hrd_old_data", bus.host_rdata, 32'hCAFEF00D);
        chk("hrd_core_rvalid", 32'(bus.core_rvalid), 32'd0);
        chk("hrd_core_rdata", bus.core_rdata, 32'd0);
        chk("sw_mem_we", 32'(bus.mem_we), 32'hF);
        chk("sw_mem_addr", 32'(bus.mem_addr), 32'h020);
        chk("sw_mem_wdata", bus.mem_wdata, 32'h12345678);
        tick();
        core_drive(1'b0, 14'h080, F3_W, 32'd0);
        tick();
        idle();
        chk("lw_new_rdata", bus.core_rdata, 32'h12345678);
        chk("lw_new_host_rvalid", 32'(bus.host_rvalid), 32'd0);

        // Six cycles of conflict
        core_drive(1'b0, 14'h000, F3_W, 32'd0);
        host_drive(1'b0, 12'h001, 4'b0000, 32'd0);
        for (int i = 0; i < 6; i++) begin
            exp_h = FAIR && (i == 4);
            #2;
            chk("conf_core_gnt", 32'(bus.core_gnt), 32'(!exp_h));
            chk("conf_host_gnt", 32'(bus.host_gnt), 32'(exp_h));
            tick();
            chk("conf_host_rvalid", 32'(bus.host_rvalid), 32'(exp_h));
            chk("conf_core_rvalid", 32'(bus.core_rvalid), 32'(!exp_h));
        end
        idle();
        tick();

        // Reset in the grant cycle of a core read
        core_drive(1'b0, 14'h010, F3_W, 32'd0);
        #2;
        chk("rstN_pre_gnt", 32'(bus.core_gnt), 32'd1);
        rst = 1'b1;
        host_drive(1'b0, 12'h020, 4'b0000, 32'd0);
        #1;
        chk("rstN_core_gnt", 32'(bus.core_gnt), 32'd0);
        chk("rstN_host_gnt", 32'(bus.host_gnt), 32'd0);
        chk("rstN_mem_en", 32'(bus.mem_en), 32'd0);
        tick();
        chk("rstN_rvalid", 32'(bus.core_rvalid), 32'd0);
        chk("rstN_rdata", bus.core_rdata, 32'd0);
        chk("rstN_mem_we", 32'(bus.mem_we), 32'd0);
        rst = 1'b0;
        idle();
        #1;
        chk("rstN_after_rvalid", 32'(bus.core_rvalid), 32'd0);
        tick();

        // Reset in the return cycle of a core read
        core_drive(1'b0, 14'h012, F3_BU, 32'd0);
        #2;
        chk("rstN1_gnt", 32'(bus.core_gnt), 32'd1);
        tick();
        idle();
        rst = 1'b1;
        #1;
        chk("rstN1_rvalid", 32'(bus.core_rvalid), 32'd0);
        chk("rstN1_offset", 32'(bus.core_rd_offset), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("rstN1_after_rvalid", 32'(bus.core_rvalid), 32'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
